// File: rtl/aux_irq_conditioner.sv
// Interrupt front end: per-channel 2-FF sync, optional debounce (DEBOUNCE_EN),
// rising-edge detect, sticky pending with ack clear, and lowest-index priority.
module aux_irq_conditioner #(
  parameter int unsigned IrqNum      = 3,
  parameter int unsigned DebounceCnt = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IrqNum-1:0] irq_raw,
  input  logic [IrqNum-1:0] mask,
  input  logic [IrqNum-1:0] ack,
  output logic [IrqNum-1:0] pend,
  output logic              req,
  output logic [1:0]        req_id
);

  localparam int unsigned IdW = 2;

  logic [IrqNum-1:0] sync1_q;
  logic [IrqNum-1:0] sync2_q;
  logic [IrqNum-1:0] ack_q;
  logic [IrqNum-1:0] lvl;
  logic [IrqNum-1:0] lvl_q;
  logic [IrqNum-1:0] rise_q;
  logic [IrqNum-1:0] pend_q;
  logic [IrqNum-1:0] pend_d;
  logic              req_q;
  logic              req_d;
  logic [IdW-1:0]    req_id_q;
  logic [IdW-1:0]    req_id_d;

  // Synchroniser, ack history, level delay and registered rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      ack_q   <= '0;
      lvl_q   <= '0;
      rise_q  <= '0;
    end else begin
      sync1_q <= irq_raw;
      sync2_q <= sync1_q;
      ack_q   <= ack;
      lvl_q   <= lvl;
      rise_q  <= lvl & ~lvl_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned CntW = (DebounceCnt > 1) ? $clog2(DebounceCnt) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCnt - 1);

  logic [CntW-1:0]   cnt_q [IrqNum];
  logic [CntW-1:0]   cnt_d [IrqNum];
  logic [IrqNum-1:0] deb_q;
  logic [IrqNum-1:0] deb_d;

  // A level is accepted only after it differs from the current one for DebounceCnt cycles
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < IrqNum; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      for (int unsigned i = 0; i < IrqNum; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int unsigned i = 0; i < IrqNum; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = sync2_q;
`endif

  // Set beats a simultaneous ack edge; priority is computed on the next-state pend
  always_comb begin
    logic found;
    pend_d   = pend_q;
    found    = 1'b0;
    req_id_d = '0;
    for (int unsigned i = 0; i < IrqNum; i++) begin
      if (rise_q[i] && mask[i]) begin
        pend_d[i] = 1'b1;
      end else if (ack[i] && !ack_q[i]) begin
        pend_d[i] = 1'b0;
      end
    end
    req_d = |pend_d;
    for (int unsigned i = 0; i < IrqNum; i++) begin
      if (pend_d[i] && !found) begin
        req_id_d = IdW'(i);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      req_q    <= 1'b0;
      req_id_q <= '0;
    end else begin
      pend_q   <= pend_d;
      req_q    <= req_d;
      req_id_q <= req_id_d;
    end
  end

  assign pend   = pend_q;
  assign req    = req_q;
  assign req_id = req_id_q;

endmodule

// File: tb/tb_aux_irq_conditioner.sv
// Directed bench for aux_irq_conditioner (IrqNum=3, DebounceCnt=4); adapts
// latency expectations to whether DEBOUNCE_EN is defined.
module tb_aux_irq_conditioner;

  localparam int unsigned IrqNum = 3;
`ifdef DEBOUNCE_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 4;
`endif

  logic              clk;
  logic              rst_n;
  logic [IrqNum-1:0] irq_raw;
  logic [IrqNum-1:0] mask;
  logic [IrqNum-1:0] ack;
  logic [IrqNum-1:0] pend;
  logic              req;
  logic [1:0]        req_id;

  int tests;
  int failed;

  aux_irq_conditioner #(
    .IrqNum     (IrqNum),
    .DebounceCnt(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_raw(irq_raw),
    .mask   (mask),
    .ack    (ack),
    .pend   (pend),
    .req    (req),
    .req_id (req_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    irq_raw = '0;
    ack     = '0;
    mask    = 3'b111;
    rst_n   = 1'b0;
    tick(2);
    rst_n   = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    irq_raw = '0;
    ack     = '0;
    mask    = 3'b111;
    rst_n   = 1'b0;
    #2;
    tests++;
    if ({pend, req, req_id} !== 6'b000_0_00) begin
      failed++;
      $display("FAIL reset_init: got pend=%b req=%b id=%0d, want 000/0/0", pend, req, req_id);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    irq_raw = 3'b100;
    tick(LAT);
    tests++;
    if (pend !== 3'b100) begin
      failed++;
      $display("FAIL reset_pre: got pend=%b want 100", pend);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({pend, req, req_id} !== 6'b000_0_00) begin
      failed++;
      $display("FAIL reset_async: got pend=%b req=%b id=%0d, want 000/0/0", pend, req, req_id);
    end
    tick(2);
    rst_n = 1'b1;
    tick(LAT - 1);
    tests++;
    if (pend !== 3'b000) begin
      failed++;
      $display("FAIL reset_requal_early: got pend=%b want 000", pend);
    end
    tick(1);
    tests++;
    if (pend !== 3'b100) begin
      failed++;
      $display("FAIL reset_requal: got pend=%b want 100", pend);
    end
  endtask

  task automatic test_single();
    do_reset();
    irq_raw = 3'b010;
    tick(LAT - 1);
    tests++;
    if (pend !== 3'b000 || req !== 1'b0) begin
      failed++;
      $display("FAIL single_early: got pend=%b req=%b want 000/0", pend, req);
    end
    tick(1);
    tests++;
    if ({pend, req, req_id} !== 6'b010_1_01) begin
      failed++;
      $display("FAIL single_set: got pend=%b req=%b id=%0d, want 010/1/1", pend, req, req_id);
    end
    ack = 3'b010;
    tick(1);
    tests++;
    if ({pend, req, req_id} !== 6'b000_0_00) begin
      failed++;
      $display("FAIL single_ack: got pend=%b req=%b id=%0d, want 000/0/0", pend, req, req_id);
    end
    irq_raw = 3'b000;
    tick(12);
    irq_raw = 3'b010;
    tick(LAT + 3);
    tests++;
    if ({pend, req, req_id} !== 6'b010_1_01) begin
      failed++;
      $display("FAIL single_ack_held: got pend=%b req=%b id=%0d, want 010/1/1", pend, req, req_id);
    end
    ack = 3'b000;
  endtask

`ifdef DEBOUNCE_EN
  task automatic test_bounce();
    do_reset();
    irq_raw = 3'b001; tick(1);
    irq_raw = 3'b000; tick(1);
    irq_raw = 3'b001; tick(1);
    irq_raw = 3'b000; tick(12);
    tests++;
    if (pend !== 3'b000) begin
      failed++;
      $display("FAIL bounce_toggle: got pend=%b want 000", pend);
    end
    irq_raw = 3'b001; tick(3);
    irq_raw = 3'b000; tick(12);
    tests++;
    if (pend !== 3'b000) begin
      failed++;
      $display("FAIL bounce_pulse3: got pend=%b want 000", pend);
    end
    irq_raw = 3'b001; tick(6);
    irq_raw = 3'b000; tick(6);
    tests++;
    if (pend !== 3'b001 || req_id !== 2'd0 || req !== 1'b1) begin
      failed++;
      $display("FAIL bounce_pulse6: got pend=%b req=%b id=%0d want 001/1/0", pend, req, req_id);
    end
  endtask
`else
  task automatic test_nodebounce();
    do_reset();
    irq_raw = 3'b001;
    tick(1);
    irq_raw = 3'b000;
    tick(2);
    tests++;
    if (pend !== 3'b000) begin
      failed++;
      $display("FAIL nodeb_early: got pend=%b want 000", pend);
    end
    tick(1);
    tests++;
    if (pend !== 3'b001 || req !== 1'b1) begin
      failed++;
      $display("FAIL nodeb_pulse: got pend=%b req=%b want 001/1", pend, req);
    end
  endtask
`endif

  task automatic test_priority_merge();
    do_reset();
    irq_raw = 3'b101;
    tick(LAT);
    tests++;
    if ({pend, req, req_id} !== 6'b101_1_00) begin
      failed++;
      $display("FAIL prio_both: got pend=%b req=%b id=%0d want 101/1/0", pend, req, req_id);
    end
    ack = 3'b001;
    tick(1);
    ack = 3'b000;
    tests++;
    if ({pend, req, req_id} !== 6'b100_1_10) begin
      failed++;
      $display("FAIL prio_ack0: got pend=%b req=%b id=%0d want 100/1/2", pend, req, req_id);
    end
    irq_raw = 3'b000;
    tick(12);
    irq_raw = 3'b100;
    tick(LAT + 4);
    tests++;
    if ({pend, req, req_id} !== 6'b100_1_10) begin
      failed++;
      $display("FAIL prio_merge: got pend=%b req=%b id=%0d want 100/1/2", pend, req, req_id);
    end
  endtask

  task automatic test_collision_mask();
    do_reset();
    irq_raw = 3'b100;
    tick(LAT - 1);
    tests++;
    if (pend !== 3'b000) begin
      failed++;
      $display("FAIL coll_early: got pend=%b want 000", pend);
    end
    ack = 3'b100;
    tick(1);
    tests++;
    if (pend !== 3'b100) begin
      failed++;
      $display("FAIL coll_set_wins: got pend=%b want 100", pend);
    end
    ack = 3'b000;
    tick(1);
    ack = 3'b100;
    tick(1);
    ack = 3'b000;
    tests++;
    if (pend !== 3'b000) begin
      failed++;
      $display("FAIL coll_ack_after: got pend=%b want 000", pend);
    end
    irq_raw = 3'b000;
    tick(12);
    mask    = 3'b011;
    irq_raw = 3'b100;
    tick(LAT + 4);
    tests++;
    if (pend !== 3'b000 || req !== 1'b0) begin
      failed++;
      $display("FAIL mask_discard: got pend=%b req=%b want 000/0", pend, req);
    end
    mask = 3'b111;
    tick(6);
    tests++;
    if (pend !== 3'b000) begin
      failed++;
      $display("FAIL unmask_no_edge: got pend=%b want 000", pend);
    end
    irq_raw = 3'b000;
    tick(12);
    irq_raw = 3'b100;
    tick(LAT);
    tests++;
    if ({pend, req, req_id} !== 6'b100_1_10) begin
      failed++;
      $display("FAIL unmask_new_edge: got pend=%b req=%b id=%0d want 100/1/2", pend, req, req_id);
    end
    mask = 3'b000;
    tick(3);
    tests++;
    if (pend !== 3'b100) begin
      failed++;
      $display("FAIL mask_keeps_pend: got pend=%b want 100", pend);
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_single();
`ifdef DEBOUNCE_EN
    test_bounce();
`else
    test_nodebounce();
`endif
    test_priority_merge();
    test_collision_mask();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
